// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit and sequencer for the E stage.
//   Holds HI/LO. A multi-cycle operation is started from E, and a busy
//   counter models its fixed latency. While an operation is in flight, a
//   D-stage stall keeps the next MDU instruction out of E.
// Ports:
//   clk, reset       rising-edge clock; synchronous active-high reset
//   e_valid          E slot holds a real instruction
//   e_mdu_op[3:0]    0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,
//                    7 MTHI,8 MTLO,9 MADD,10 MADDU (11..15 = NONE)
//   e_rs, e_rt       forwarded operands in E
//   d_is_mdu         D-stage instruction is an MDU op
//   busy             operation in flight (cnt != 0)
//   stall_d          freeze F/D and bubble E
//   hilo_rdata       HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo           HI/LO registers
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (codes 9/10).
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_mdu_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } op_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        start;
  op_t         op_in;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  assign op_in = op_t'(e_mdu_op);

  // Sign-extended 64x64 multiply; the low 64 bits equal the signed product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Division is guarded so a zero divisor never produces X.
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_q != '0) begin
      quot_s = $signed(a_q) / $signed(b_q);
      rem_s  = $signed(a_q) % $signed(b_q);
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (e_valid) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              start = 1'b1;
              cnt_d = 4'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
              start = 1'b1;
              cnt_d = 4'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              start = 1'b1;
              cnt_d = 4'(MULT_CYCLES);
            end
`endif
            OP_MTHI: hi_d = e_rs;
            OP_MTLO: lo_d = e_rs;
            default: ;
          endcase
        end
        if (start) begin
          state_d = BUSY;
          op_d    = op_in;
          a_d     = e_rs;
          b_d     = e_rt;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != '0) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != '0) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (cnt_q != '0);
  // The start term catches an MDU op in D directly behind one entering E.
  assign stall_d = d_is_mdu && (start || busy);
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    hilo_rdata = '0;
    if (e_valid) begin
      if (op_in == OP_MFHI)      hilo_rdata = hi_q;
      else if (op_in == OP_MFLO) hilo_rdata = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_mdu_op;
  logic [31:0] e_rs, e_rt;
  logic        d_is_mdu;
  logic        busy, stall_d;
  logic [31:0] hilo_rdata, hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_mdu_op(e_mdu_op),
    .e_rs(e_rs), .e_rt(e_rt), .d_is_mdu(d_is_mdu), .busy(busy),
    .stall_d(stall_d), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // An MDU op must never reach E while an operation is in flight.
  always @(posedge clk) begin
    if (!reset && busy && e_valid && e_mdu_op >= 4'd1 && e_mdu_op <= 4'd10) begin
      errors++;
      $display("FAIL busy_collision op=%0d while busy", e_mdu_op);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    e_valid = 1'b0; e_mdu_op = 4'd0; e_rs = '0; e_rt = '0; d_is_mdu = 1'b0;
  endtask

  // Presents one instruction in E for one edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    e_valid = 1'b1; e_mdu_op = op; e_rs = rs; e_rt = rt;
    step();
    idle_inputs();
  endtask

  // Issues a multi-cycle op and counts busy cycles (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int n);
    issue(op, rs, rt);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_d !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h stall=%b want 0/0/0/0", busy, hi, lo, stall_d);
    end
  endtask

  task automatic test_mthi_mfhi();
    issue(4'd7, 32'h12345678, 32'd0);
    checks++;
    if (hi !== 32'h12345678) begin
      errors++; $display("FAIL mthi hi=%h want 12345678", hi);
    end
    e_valid = 1'b1; e_mdu_op = 4'd5;
    #1;
    checks++;
    if (hilo_rdata !== 32'h12345678 || busy !== 1'b0) begin
      errors++; $display("FAIL mfhi rdata=%h busy=%b want 12345678/0", hilo_rdata, busy);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hilo_rdata !== 32'd0) begin
      errors++; $display("FAIL rdata_idle rdata=%h want 0", hilo_rdata);
    end
  endtask

  task automatic test_mult();
    int n;
    run_op(4'd1, 32'hFFFFFFFF, 32'h00000002, n);
    checks++;
    if (n != 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL mult cycles=%0d hi=%h lo=%h want 5 ffffffff fffffffe", n, hi, lo);
    end
    run_op(4'd2, 32'hFFFFFFFF, 32'h00000002, n);
    checks++;
    if (n != 5 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu cycles=%0d hi=%h lo=%h want 5 00000001 fffffffe", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    run_op(4'd3, 32'hFFFFFFF9, 32'h00000002, n);
    checks++;
    if (n != 10 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div cycles=%0d hi=%h lo=%h want 10 ffffffff fffffffd", n, hi, lo);
    end
    run_op(4'd4, 32'd7, 32'd2, n);
    checks++;
    if (n != 10 || lo !== 32'd3 || hi !== 32'd1) begin
      errors++; $display("FAIL divu cycles=%0d hi=%h lo=%h want 10 1 3", n, hi, lo);
    end
  endtask

  task automatic test_stall();
    e_valid = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd3; e_rt = 32'd7; d_is_mdu = 1'b1;
    #1;
    checks++;
    if (stall_d !== 1'b1) begin
      errors++; $display("FAIL stall_start stall=%b want 1", stall_d);
    end
    step();
    e_valid = 1'b0; e_mdu_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || stall_d !== 1'b1) begin
        errors++; $display("FAIL stall_busy cyc=%0d busy=%b stall=%b want 1/1", i, busy, stall_d);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || stall_d !== 1'b0) begin
      errors++; $display("FAIL stall_release busy=%b stall=%b want 0/0", busy, stall_d);
    end
    d_is_mdu = 1'b0; e_valid = 1'b1; e_mdu_op = 4'd6;
    #1;
    checks++;
    if (hilo_rdata !== 32'd21 || hi !== 32'd0) begin
      errors++; $display("FAIL mflo_product rdata=%h hi=%h want 15 0", hilo_rdata, hi);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_div_zero_and_reset();
    int n;
    issue(4'd7, 32'hAAAA0000, 32'd0);
    issue(4'd8, 32'h0000BBBB, 32'd0);
    run_op(4'd3, 32'd5, 32'd0, n);
    checks++;
    if (n != 10 || hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) begin
      errors++; $display("FAIL div_zero cycles=%0d hi=%h lo=%h want 10 aaaa0000 0000bbbb", n, hi, lo);
    end
    issue(4'd3, 32'd100, 32'd7);
    step(); step(); step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL div_inflight busy=%b want 1", busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_abort busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL no_late_commit busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_madd();
    int n;
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    run_op(4'd10, 32'd1, 32'd1, n);
    checks++;
    if (n != 5 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL maddu cycles=%0d hi=%h lo=%h want 5 1 0", n, hi, lo);
    end
`else
    run_op(4'd10, 32'd1, 32'd1, n);
    checks++;
    if (n != 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL maddu_off cycles=%0d hi=%h lo=%h want 0 0 ffffffff", n, hi, lo);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL maddu_off_late busy=%b hi=%h lo=%h want 0 0 ffffffff", busy, hi, lo);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_mthi_mfhi();
    test_mult();
    test_div();
    test_stall();
    test_div_zero_and_reset();
    test_madd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit and its sequencer for the pipelined MIPS core, sitting in the E stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E.
- Holds HI/LO and models fixed multi-cycle latency with a busy counter.
- Generates the D-stage stall that keeps a later MDU instruction out of E while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  clock; every register updates on its rising edge
reset  input  1  synchronous, active-high reset
e_valid  input  1  E-stage slot holds a real instruction (0 for bubble or flush)
e_mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU
e_rs  input  32  forwarded rs value in E
e_rt  input  32  forwarded rt value in E
d_is_mdu  input  1  D-stage instruction is any MDU op (codes 1..10)
busy  output  1  operation in flight
stall_d  output  1  freeze F/D and insert an E bubble
hilo_rdata  output  32  MFHI gives HI, MFLO gives LO, otherwise 0 (combinational)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (synchronous): hi=0, lo=0, cnt=0, busy=0, operand and op latches cleared. Reset wins over every other event in the same cycle, including an in-flight operation; that operation is discarded with no HI/LO write.
- States:
  - IDLE: cnt==0.
  - BUSY: cnt!=0. busy = (cnt!=0), taken directly from the register.
- start = e_valid && !busy && e_mdu_op in {1,2,3,4}; also {9,10} when the optional feature is compiled in.
- On the start edge: latch e_rs, e_rt and the op; cnt <= MULT_CYCLES or DIV_CYCLES. busy is therefore high for exactly N cycles after the start edge.
- Each BUSY edge decrements cnt.
- When cnt==1 at an edge, commit the result and set cnt <= 0. busy falls in the cycle in which HI/LO are already updated.
- Results:
  - MULT: {hi,lo} = signed 32x32 product (64 bits).
  - MULTU: {hi,lo} = unsigned 32x32 product (64 bits).
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Divisor 0: the full busy time elapses and HI/LO are left unchanged.
- MTHI/MTLO (e_valid && !busy): hi or lo <= e_rs on that edge. MFHI/MFLO read the pre-edge register value.
- An MDU op presented in E while busy is ignored. The stall logic guarantees this cannot occur; the bench asserts it never does.
- stall_d = d_is_mdu && (start || busy). The combinational start term covers back-to-back MDU instructions.
- Op codes 11..15: treated as NONE. Codes 9 and 10 are also NONE when the feature is compiled out.
- No other outputs depend on e_valid==0 inputs.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: codes 9/10 (MADD/MADDU) start a MULT_CYCLES operation. On commit, {hi,lo} <= {hi,lo} + signed or unsigned 64-bit product, using the HI/LO value at commit time; the sum wraps modulo 2^64.
- Undefined: codes 9/10 behave as NONE. They do not start, do not set busy and do not write HI/LO. stall_d still follows d_is_mdu.

Test Plan:
1. Reset, then MTHI rs=0x12345678, then MFHI -> hi=0x12345678 after the edge; hilo_rdata=0x12345678 during MFHI; busy stays 0.
2. MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE.
3. DIV rs=0xFFFFFFF9 rt=0x00000002 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3 hi=1.
4. MULT in E with d_is_mdu=1 -> stall_d=1 on the start cycle and all 5 busy cycles; stall_d=0 in the cycle busy falls. MFLO then reads the product.
5. Preset hi=0xAAAA0000 lo=0x0000BBBB; DIV by rt=0 -> busy 10 cycles, hi/lo unchanged. Reset asserted on the 4th busy cycle of another DIV -> next cycle busy=0, hi=lo=0, no later commit.
6. With MDU_MADD_EN: hi=0 lo=0xFFFFFFFF, MADDU rs=1 rt=1 -> after 5 cycles hi=1 lo=0. Without MDU_MADD_EN: same stimulus -> busy never rises, hi/lo unchanged.
